// File: rtl/gradient_magnitude.sv
// Sobel gradient magnitude (L1 / MAX / alpha-max-beta-min), scaled and saturated to OUT_WIDTH_P.
// Latency: 3 register stages (abs, combine, scale/saturate); throughput 1 pair per cycle.
// Backpressure: valid/ready with bubble collapsing; ready_o combinationally follows ready_i when full.
// Optional threshold compare output enabled by defining GRADIENT_MAGNITUDE_THRESH_EN.
module gradient_magnitude #(
  parameter int WIDTH_P     = 11,
  parameter int OUT_WIDTH_P = 8,
  parameter int SHIFT_P     = 2
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic signed [WIDTH_P-1:0] gx_i,
  input  logic signed [WIDTH_P-1:0] gy_i,
  input  logic [1:0]                mode_i,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [OUT_WIDTH_P-1:0]    mag_o
`ifdef GRADIENT_MAGNITUDE_THRESH_EN
  ,
  input  logic [OUT_WIDTH_P-1:0]    thresh_i,
  output logic                      edge_o
`endif
);

  localparam int CW = WIDTH_P + 1;

  typedef enum logic [1:0] {
    MODE_L1   = 2'b00,
    MODE_MAX  = 2'b01,
    MODE_AMBM = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  typedef struct packed {
    logic [WIDTH_P-1:0] ax;
    logic [WIDTH_P-1:0] ay;
    mode_e              mode;
  } s1_t;

  // Absolute value kept as WIDTH_P-bit unsigned so the most negative input maps to 2^(WIDTH_P-1).
  function automatic logic [WIDTH_P-1:0] abs_f(input logic [WIDTH_P-1:0] v);
    return v[WIDTH_P-1] ? (~v + WIDTH_P'(1)) : v;
  endfunction

  logic               s1_vld, s2_vld, s3_vld;
  s1_t                s1_dat;
  logic [CW-1:0]      s2_dat;
  logic [OUT_WIDTH_P-1:0] s3_dat;

  logic s1_free, s2_free, s3_free;

  // A stage may load when it is empty or its content leaves this cycle.
  assign s3_free = !s3_vld || ready_i;
  assign s2_free = !s2_vld || s3_free;
  assign s1_free = !s1_vld || s2_free;
  assign ready_o = s1_free;

  assign valid_o = s3_vld;
  assign mag_o   = s3_dat;

  logic [WIDTH_P-1:0] mx, mn;
  logic [CW-1:0]      comb_nx;
  logic [CW-1:0]      scaled;
  logic               sat;
  logic [OUT_WIDTH_P-1:0] mag_nx;

  // Combine stage: pick the magnitude approximation selected by the pair's own mode.
  always_comb begin
    mx      = (s1_dat.ax >= s1_dat.ay) ? s1_dat.ax : s1_dat.ay;
    mn      = (s1_dat.ax >= s1_dat.ay) ? s1_dat.ay : s1_dat.ax;
    comb_nx = CW'(s1_dat.ax) + CW'(s1_dat.ay);
    case (s1_dat.mode)
      MODE_MAX:  comb_nx = CW'(mx);
      MODE_AMBM: comb_nx = CW'(mx) + CW'(mn >> 2) + CW'(mn >> 3);
      default:   comb_nx = CW'(s1_dat.ax) + CW'(s1_dat.ay);
    endcase
  end

  // Scale stage: right shift, then clamp anything above the output range to all-ones.
  always_comb begin
    scaled = s2_dat >> SHIFT_P;
    sat    = (scaled >> OUT_WIDTH_P) != '0;
    mag_nx = sat ? '1 : OUT_WIDTH_P'(scaled);
  end

  // S1: register absolute gradients and the mode that travels with them.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      s1_vld <= 1'b0;
      s1_dat <= '0;
    end else if (s1_free) begin
      s1_vld <= valid_i;
      if (valid_i) begin
        s1_dat.ax   <= abs_f(gx_i);
        s1_dat.ay   <= abs_f(gy_i);
        s1_dat.mode <= mode_e'(mode_i);
      end
    end
  end

  // S2: register the combined (unscaled) magnitude.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      s2_vld <= 1'b0;
      s2_dat <= '0;
    end else if (s2_free) begin
      s2_vld <= s1_vld;
      if (s1_vld) s2_dat <= comb_nx;
    end
  end

  // S3: register the saturated output; held stable while downstream stalls.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      s3_vld <= 1'b0;
      s3_dat <= '0;
    end else if (s3_free) begin
      s3_vld <= s2_vld;
      if (s2_vld) s3_dat <= mag_nx;
    end
  end

`ifdef GRADIENT_MAGNITUDE_THRESH_EN
  // Edge flag computed against the threshold present as the pair enters S3.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      edge_o <= 1'b0;
    end else if (s3_free && s2_vld) begin
      edge_o <= (mag_nx >= thresh_i);
    end
  end
`endif

endmodule
